div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Controller and iterative datapath for LoongArch 32-bit integer division: div.w, mod.w, div.wu, mod.wu.
- Sits beside the EX stage. EX issues one request with a valid/ready handshake; the block runs a 32-step restoring division and returns the result to EX/MEM with a valid/ready handshake.
- busy and busy_rd feed the data-hazard logic so that dependent instructions stall while a divide is outstanding.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  EX presents a divide request
- in_ready  out  1  block can accept a request
- op  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
- src1  in  32  dividend
- src2  in  32  divisor
- rd  in  5  destination register of the request
- flush  in  1  exception/ertn flush; kills the in-flight operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  32  quotient or remainder, selected by op
- out_rd  out  5  destination register of the result
- busy  out  1  an operation is in flight (state != IDLE)
- busy_rd  out  5  latched rd of the in-flight operation

Behaviour:

Reset (resetn=0, asynchronous):
- state=IDLE; counter=0; all internal registers 0.
- Outputs: out_valid=0, busy=0, result=0, out_rd=0, busy_rd=0. in_ready=1 once reset is released.
- Reset asserted mid-CALC or mid-DONE aborts immediately; no result is ever produced for that operation.

States:
- IDLE: in_ready=1.
  - Accept when in_valid & in_ready & ~flush.
  - On accept, latch op, rd, sign flags and magnitudes (|src1|, |src2| for signed ops; raw values for unsigned).
  - Clear the remainder register and the counter.
  - If src2==0, go to DONE; otherwise go to CALC.
- CALC: one quotient bit per cycle.
  - Shift {rem, dividend} left by 1.
  - If rem >= divisor, then rem -= divisor and set the quotient bit.
  - counter increments 0..31; after the step with counter==31, go to DONE.
- DONE: out_valid = ~flush.
  - Leave for IDLE when out_valid & out_ready.
  - Otherwise hold; result and out_rd stay stable while waiting.
- Any state with flush=1: next state IDLE, busy drops the next cycle. flush has priority over accept and over output handshake.

Latency and throughput:
- Accept on the edge ending cycle T: CALC during T+1..T+32, out_valid first high in T+33.
- Divide-by-zero: out_valid high in T+1.
- in_ready=0 in CALC and DONE. The earliest next accept is the cycle after the output handshake, so back-to-back divides cost one bubble.

Result rules:
- Quotient sign = src1[31] ^ src2[31] for signed ops. Remainder sign = src1[31] for signed ops. Negation is applied combinationally in DONE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0. This falls out of 32-bit wrap; no special case.
- Divisor zero, all ops: q=0xFFFFFFFF, r=src1 (raw, no sign fixing).
- result = quotient for op[0]=0, remainder for op[0]=1.

Bookkeeping outputs:
- busy=1 from the cycle after accept until the cycle after the output handshake or flush.
- busy_rd is valid whenever busy=1. out_rd equals busy_rd while in DONE.
- result is 0 outside DONE.

Test Plan:
1. div.w src1=100, src2=0xFFFFFFF9 (-7), out_ready=1 -> in_ready low T+1..T+33; out_valid at T+33, result=0xFFFFFFF2 (-14); repeat with mod.w -> result=2.
2. mod.w src1=0xFFFFFF9C (-100), src2=7 -> result=0xFFFFFFFE (-2). div.wu src1=0xFFFFFFFF, src2=2 -> result=0x7FFFFFFF.
3. div.wu 5/0 -> out_valid at T+1, result=0xFFFFFFFF. mod.w 0xFFFFFFFB/0 -> result=0xFFFFFFFB. Counter never advances.
4. div.w 0x80000000 / 0xFFFFFFFF -> result=0x80000000; mod.w on the same operands -> result=0, no hang.
5. Accept rd=5, pulse flush at T+10 -> busy=0 at T+11, out_valid never rises; new request accepted at T+11 completes correctly at T+44.
6. Hold out_ready=0 for 5 cycles in DONE -> out_valid, result and out_rd stable, in_ready=0. Then out_ready=1 -> IDLE next cycle. Separately, assert resetn=0 at T+15 -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle between EX and the iterative divider.
// master = EX side, slave = divider side.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [4:0]       rd;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       out_rd;
  logic             busy;
  logic [4:0]       busy_rd;

  modport master (
    output in_valid, op, src1, src2, rd, flush, out_ready,
    input  in_ready, out_valid, result, out_rd, busy, busy_rd
  );

  modport slave (
    input  in_valid, op, src1, src2, rd, flush, out_ready,
    output in_ready, out_valid, result, out_rd, busy, busy_rd
  );
endinterface

// File: rtl/div_ctrl.sv
// Iterative restoring divider for div.w/mod.w/div.wu/mod.wu: magnitudes are
// divided one quotient bit per cycle; signs are restored combinationally in DONE.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic  clk,
  input  logic  resetn,
  div_if.slave  bus
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_sel_rem;
  logic [4:0]       r_rd;
  logic             r_qneg, r_rneg, r_dz;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem;

  logic                    w_accept, w_dz, w_s1neg, w_s2neg, w_qbit;
  logic signed [WIDTH-1:0] w_src1_s, w_src2_s;
  logic [WIDTH:0]          w_shift, w_diff;
  logic [WIDTH-1:0]        w_quo, w_rmd;

  function automatic logic [WIDTH-1:0] f_neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  assign w_src1_s = bus.src1;
  assign w_src2_s = bus.src2;
  assign w_dz     = (bus.src2 == '0);
  assign w_s1neg  = ~bus.op[1] & (w_src1_s < 0);
  assign w_s2neg  = ~bus.op[1] & (w_src2_s < 0);
  assign w_accept = bus.in_valid & (r_state == S_IDLE) & ~bus.flush;

  // Restoring step: a clear borrow bit means the shifted remainder covers the divisor.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_qbit  = ~w_diff[WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (w_accept) w_next = w_dz ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == CW'(ITER - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = ~bus.flush;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_sel_rem <= 1'b0;
      r_rd      <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_sel_rem <= bus.op[0];
      r_rd      <= bus.rd;
      r_qneg    <= w_s1neg ^ w_s2neg;
      r_rneg    <= w_s1neg;
      r_dz      <= w_dz;
      // A zero divisor returns the raw dividend as remainder, so skip sign stripping.
      r_dvd     <= w_dz ? bus.src1 : f_neg_if(w_s1neg, bus.src1);
      r_dvs     <= f_neg_if(w_s2neg, bus.src2);
      r_rem     <= '0;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
    end
  end

  assign w_quo = r_dz ? '1    : f_neg_if(r_qneg, r_dvd);
  assign w_rmd = r_dz ? r_dvd : f_neg_if(r_rneg, r_rem);

  assign bus.result  = (r_state == S_DONE) ? (r_sel_rem ? w_rmd : w_quo) : '0;
  assign bus.out_rd  = (r_state == S_DONE) ? r_rd : '0;
  assign bus.busy_rd = r_rd;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: transaction-level model checked every cycle, plus
// directed vectors with literal results and latencies.
module tb_div_ctrl;
  logic clk    = 1'b0;
  logic resetn = 1'b0;

  div_if #(.WIDTH(32)) bus();

  div_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model state: one outstanding op, cycles left until its result shows.
  bit          m_pending = 1'b0;
  int          m_wait    = 0;
  logic [31:0] m_res     = '0;
  logic [4:0]  m_rd      = '0;

  int          acc_cyc    = 0;
  int          last_lat   = -1;
  bit          seen_valid = 1'b0;
  logic [31:0] last_res   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return op[0] ? a : 32'hFFFF_FFFF;
    if (!op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[0] ? r[31:0] : q[31:0];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pending = 1'b0;
      m_wait    = 0;
    end else begin
      if (bus.flush) begin
        m_pending = 1'b0;
      end else if (!m_pending) begin
        if (bus.in_valid) begin
          m_pending  = 1'b1;
          m_wait     = (bus.src2 == 32'h0) ? 0 : 32;
          m_res      = f_model(bus.op, bus.src1, bus.src2);
          m_rd       = bus.rd;
          acc_cyc    = cyc;
          seen_valid = 1'b0;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (bus.out_ready) begin
        m_pending = 1'b0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic in_done;
    in_done = m_pending && (m_wait == 0);
    chk("out_valid", 32'(bus.out_valid), 32'(in_done && !bus.flush));
    chk("busy",      32'(bus.busy),      32'(m_pending));
    chk("in_ready",  32'(bus.in_ready),  32'(!m_pending));
    chk("result",    bus.result,         in_done ? m_res : 32'h0);
    chk("out_rd",    32'(bus.out_rd),    in_done ? 32'(m_rd) : 32'h0);
    if (m_pending) chk("busy_rd", 32'(bus.busy_rd), 32'(m_rd));
    if (bus.out_valid && !seen_valid) begin
      seen_valid = 1'b1;
      last_lat   = cyc - acc_cyc;
    end
    if (bus.out_valid && bus.out_ready) last_res = bus.result;
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.op       = op;
    bus.src1     = a;
    bus.src2     = b;
    bus.rd       = rd;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input logic [31:0] exp_res, input int exp_lat);
    int n;
    bus.out_ready = 1'b1;
    last_res      = 32'hDEAD_BEEF;
    last_lat      = -1;
    issue(op, a, b, rd);
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_complete"}, 32'(bus.busy), 32'h0);
    chk({name, "_res"},      last_res,      exp_res);
    chk({name, "_lat"},      32'(last_lat), 32'(exp_lat));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({name, "_busy"},      32'(bus.busy),      32'h0);
    chk({name, "_result"},    bus.result,         32'h0);
    chk({name, "_out_rd"},    32'(bus.out_rd),    32'h0);
    chk({name, "_busy_rd"},   32'(bus.busy_rd),   32'h0);
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.rd        = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    resetn        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'h1);

    run("divw_pos_neg",  2'b00, 32'd100,       32'hFFFF_FFF9, 5'd3,  32'hFFFF_FFF2, 33);
    run("modw_pos_neg",  2'b01, 32'd100,       32'hFFFF_FFF9, 5'd4,  32'h0000_0002, 33);
    run("modw_neg_pos",  2'b01, 32'hFFFF_FF9C, 32'd7,         5'd6,  32'hFFFF_FFFE, 33);
    run("divwu_max",     2'b10, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'h7FFF_FFFF, 33);
    run("divwu_zero",    2'b10, 32'd5,         32'h0,         5'd8,  32'hFFFF_FFFF, 1);
    run("modw_zero",     2'b01, 32'hFFFF_FFFB, 32'h0,         5'd9,  32'hFFFF_FFFB, 1);
    run("divw_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 33);
    run("modw_ovf",      2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 33);

    // Flush in T+10 kills the op; the next request goes in at T+11.
    issue(2'b00, 32'd1000, 32'd7, 5'd5);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy_drop", 32'(bus.busy), 32'h0);
    run("modwu_after_flush", 2'b11, 32'd1000, 32'd7, 5'd12, 32'd6, 33);

    // Consumer stalls for 5 cycles in DONE.
    bus.out_ready = 1'b0;
    issue(2'b00, 32'd12345, 32'hFFFF_FFFD, 5'd13);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_valid_rise", 32'(bus.out_valid), 32'h1);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_valid",    32'(bus.out_valid), 32'h1);
    chk("stall_result",   bus.result,         32'hFFFF_EFED);
    chk("stall_out_rd",   32'(bus.out_rd),    32'd13);
    chk("stall_in_ready", 32'(bus.in_ready),  32'h0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_busy",  32'(bus.busy),     32'h0);
    chk("stall_release_ready", 32'(bus.in_ready), 32'h1);

    // Reset asserted mid-CALC in T+15.
    issue(2'b00, 32'd50, 32'd5, 5'd14);
    repeat (14) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run("divwu_after_reset", 2'b10, 32'd50, 32'd5, 5'd15, 32'd10, 33);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
